// File: rtl/gpu_pixel_writer.sv
// Pixel-stream sink: clips incoming pixels, buffers them in a small FIFO and
// writes each one to a linear framebuffer over a req/ack port.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_pixel_writer #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_BITS  = 19,
  parameter int unsigned CNT_BITS   = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_valid_i,
  input  logic [`WIDTH_BITS-1:0]      X_i,
  input  logic [`HEIGHT_BITS-1:0]     Y_i,
  input  logic [`CHANNEL_BITS-1:0]    r_i,
  input  logic [`CHANNEL_BITS-1:0]    g_i,
  input  logic [`CHANNEL_BITS-1:0]    b_i,
  input  logic                        frame_done_i,
  output logic                        stall_o,
  output logic                        mem_req_o,
  output logic [ADDR_BITS-1:0]        mem_addr_o,
  output logic [3*`CHANNEL_BITS-1:0]  mem_data_o,
  input  logic                        mem_ack_i,
  output logic                        flush_done_o,
  output logic                        overflow_o,
  output logic                        idle_o,
  output logic [CNT_BITS-1:0]         written_cnt_o,
  output logic [CNT_BITS-1:0]         clipped_cnt_o
);

  localparam int unsigned XW      = `WIDTH_BITS;
  localparam int unsigned YW      = `HEIGHT_BITS;
  localparam int unsigned DW      = 3 * `CHANNEL_BITS;
  localparam int unsigned ENTRY_W = XW + YW + DW;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_REQ} state_t;

  state_t state, state_next;
  logic   load_addr;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;
  logic               full, empty, in_range, push, pop, drop, clip;
  logic               done_pend, flush_fire;
  logic [ENTRY_W-1:0] head;
  logic [XW-1:0]      head_x;
  logic [YW-1:0]      head_y;
  logic [DW-1:0]      head_rgb;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_range = (32'(X_i) < SCREEN_W) && (32'(Y_i) < SCREEN_H);
  assign clip     = pix_valid_i & ~in_range;
  assign push     = pix_valid_i & in_range & ~full;
  assign drop     = pix_valid_i & in_range & full;
  assign pop      = (state == S_REQ) & mem_ack_i;

  assign head     = fifo_mem[rd_ptr];
  assign head_x   = head[ENTRY_W-1 -: XW];
  assign head_y   = head[DW+YW-1 -: YW];
  assign head_rgb = head[DW-1:0];

  assign stall_o    = full;
  assign mem_req_o  = (state == S_REQ);
  assign flush_fire = done_pend & empty & (state == S_IDLE);
  assign idle_o     = empty & (state == S_IDLE) & ~done_pend;

  // Storage itself needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {X_i, Y_i, r_i, g_i, b_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    case (state)
      S_IDLE: if (!empty) state_next = S_ADDR;
      S_ADDR: begin
        load_addr  = 1'b1;
        state_next = S_REQ;
      end
      S_REQ:  if (mem_ack_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Product is taken modulo 2^ADDR_BITS, identical to truncating the full product.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (load_addr) begin
      mem_addr_o <= ADDR_BITS'(head_y) * ADDR_BITS'(SCREEN_W) + ADDR_BITS'(head_x);
      mem_data_o <= head_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_o    <= 1'b0;
      written_cnt_o <= '0;
      clipped_cnt_o <= '0;
      done_pend     <= 1'b0;
      flush_done_o  <= 1'b0;
    end else begin
      if (drop) overflow_o <= 1'b1;
      if (pop && written_cnt_o != '1) written_cnt_o <= written_cnt_o + CNT_BITS'(1);
      if (clip && clipped_cnt_o != '1) clipped_cnt_o <= clipped_cnt_o + CNT_BITS'(1);
      // A done arriving while one is already pending (or firing) is absorbed.
      done_pend    <= flush_fire ? 1'b0 : (done_pend | frame_done_i);
      flush_done_o <= flush_fire;
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer: vector table for single pixels plus
// hand-written latency, backpressure, flush and mid-request reset sequences.
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module tb_gpu_pixel_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid_i;
  logic [9:0]  X_i;
  logic [8:0]  Y_i;
  logic [7:0]  r_i, g_i, b_i;
  logic        frame_done_i;
  logic        stall_o;
  logic        mem_req_o;
  logic [18:0] mem_addr_o;
  logic [23:0] mem_data_o;
  logic        mem_ack_i;
  logic        flush_done_o;
  logic        overflow_o;
  logic        idle_o;
  logic [19:0] written_cnt_o;
  logic [19:0] clipped_cnt_o;

  gpu_pixel_writer dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid_i), .X_i(X_i), .Y_i(Y_i),
    .r_i(r_i), .g_i(g_i), .b_i(b_i), .frame_done_i(frame_done_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .flush_done_o(flush_done_o),
    .overflow_o(overflow_o), .idle_o(idle_o), .written_cnt_o(written_cnt_o),
    .clipped_cnt_o(clipped_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int flush_cnt = 0;
  int exp_written = 0;
  int exp_clipped = 0;

  always @(negedge clk) if (flush_done_o) flush_cnt++;

  typedef struct {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
    bit          clip;
    logic [18:0] addr;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [8:0] y, input logic [23:0] rgb);
    pix_valid_i = 1'b1;
    X_i = x;
    Y_i = y;
    r_i = rgb[23:16];
    g_i = rgb[15:8];
    b_i = rgb[7:0];
  endtask

  task automatic wait_req(input string nm);
    for (int i = 0; i < 20 && !mem_req_o; i++) tick();
    check(nm, 32'(mem_req_o), 32'd1);
  endtask

  task automatic ack_once();
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
  endtask

  initial begin
    int base;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [23:0] pd;

    vecs[0] = '{10'd640, 9'd0,   24'h112233, 1'b1, 19'd0};
    vecs[1] = '{10'd0,   9'd480, 24'h445566, 1'b1, 19'd0};
    vecs[2] = '{10'd639, 9'd479, 24'hABCDEF, 1'b0, 19'd307199};
    vecs[3] = '{10'd0,   9'd0,   24'h0C2238, 1'b0, 19'd0};
    vecs[4] = '{10'd1,   9'd1,   24'h800001, 1'b0, 19'd641};
    vecs[5] = '{10'd1023,9'd10,  24'h777777, 1'b1, 19'd0};
    vecs[6] = '{10'd0,   9'd479, 24'h000000, 1'b0, 19'd306560};

    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_valid_i  = 1'($urandom_range(0, 1));
      X_i          = 10'($urandom);
      Y_i          = 9'($urandom);
      r_i          = 8'($urandom);
      g_i          = 8'($urandom);
      b_i          = 8'($urandom);
      frame_done_i = 1'($urandom_range(0, 1));
      mem_ack_i    = 1'($urandom_range(0, 1));
      tick();
    end
    check("rst_req", 32'(mem_req_o), 0);
    check("rst_flush", 32'(flush_done_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_stall", 32'(stall_o), 0);
    check("rst_idle", 32'(idle_o), 1);
    check("rst_addr", 32'(mem_addr_o), 0);
    check("rst_data", 32'(mem_data_o), 0);
    check("rst_wcnt", 32'(written_cnt_o), 0);
    check("rst_ccnt", 32'(clipped_cnt_o), 0);
    rst = 1'b0;
    pix_valid_i = 1'b0;
    frame_done_i = 1'b0;
    mem_ack_i = 1'b0;
    tick();

    // Single pixel latency
    drive_pix(10'd320, 9'd240, 24'hFFFFFF);
    tick();
    pix_valid_i = 1'b0;
    check("lat_n0", 32'(mem_req_o), 0);
    tick();
    check("lat_n1", 32'(mem_req_o), 0);
    tick();
    check("lat_n2", 32'(mem_req_o), 1);
    check("lat_addr", 32'(mem_addr_o), 32'd153920);
    check("lat_data", 32'(mem_data_o), 32'hFFFFFF);
    ack_once();
    exp_written++;
    check("lat_req_drop", 32'(mem_req_o), 0);
    check("lat_wcnt", 32'(written_cnt_o), 32'(exp_written));
    check("lat_idle", 32'(idle_o), 1);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      drive_pix(vecs[v].x, vecs[v].y, vecs[v].rgb);
      tick();
      pix_valid_i = 1'b0;
      if (vecs[v].clip) begin
        exp_clipped++;
        check("vec_ccnt", 32'(clipped_cnt_o), 32'(exp_clipped));
        tick();
        tick();
        check("vec_clip_noreq", 32'(mem_req_o), 0);
        check("vec_clip_idle", 32'(idle_o), 1);
      end else begin
        wait_req("vec_req");
        check("vec_addr", 32'(mem_addr_o), 32'(vecs[v].addr));
        check("vec_data", 32'(mem_data_o), 32'(vecs[v].rgb));
        ack_once();
        exp_written++;
        check("vec_wcnt", 32'(written_cnt_o), 32'(exp_written));
      end
    end

    // Backpressure: 6 pixels, ack held low
    for (int k = 0; k < 6; k++) begin
      px = 10'(10 + k);
      py = 9'(20 + k);
      pd = {8'(k), 8'(k + 16), 8'(k + 32)};
      drive_pix(px, py, pd);
      tick();
      check("bp_stall", 32'(stall_o), (k >= 3) ? 32'd1 : 32'd0);
      check("bp_ovf", 32'(overflow_o), (k >= 4) ? 32'd1 : 32'd0);
    end
    pix_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_req("bp_req");
      check("bp_addr", 32'(mem_addr_o), 32'((20 + k) * 640 + 10 + k));
      check("bp_data", 32'(mem_data_o), {8'd0, 8'(k), 8'(k + 16), 8'(k + 32)});
      ack_once();
      exp_written++;
    end
    for (int i = 0; i < 5; i++) tick();
    check("bp_no_extra", 32'(mem_req_o), 0);
    check("bp_wcnt", 32'(written_cnt_o), 32'(exp_written));
    check("bp_ovf_sticky", 32'(overflow_o), 1);
    check("bp_stall_clr", 32'(stall_o), 0);

    // Flush: 3 pixels, frame done, slow acks, repeated done absorbed
    base = flush_cnt;
    for (int k = 0; k < 3; k++) begin
      drive_pix(10'(100 + k), 9'd50, 24'(k + 1));
      tick();
    end
    pix_valid_i = 1'b0;
    frame_done_i = 1'b1;
    tick();
    frame_done_i = 1'b0;
    check("fl_not_idle", 32'(idle_o), 0);
    for (int k = 0; k < 3; k++) begin
      wait_req("fl_req");
      check("fl_addr", 32'(mem_addr_o), 32'(50 * 640 + 100 + k));
      for (int d = 0; d < 5; d++) begin
        frame_done_i = (k == 1 && d == 2);
        tick();
      end
      frame_done_i = 1'b0;
      check("fl_req_hold", 32'(mem_req_o), 1);
      check("fl_no_early", 32'(flush_done_o), 0);
      ack_once();
      exp_written++;
    end
    check("fl_after_ack", 32'(flush_done_o), 0);
    tick();
    check("fl_pulse", 32'(flush_done_o), 1);
    tick();
    check("fl_pulse_end", 32'(flush_done_o), 0);
    for (int i = 0; i < 5; i++) tick();
    check("fl_once", 32'(flush_cnt - base), 1);
    check("fl_idle", 32'(idle_o), 1);
    check("fl_wcnt", 32'(written_cnt_o), 32'(exp_written));

    // Reset while in REQ with 2 pixels buffered
    base = flush_cnt;
    drive_pix(10'd5, 9'd6, 24'h123456);
    tick();
    drive_pix(10'd7, 9'd8, 24'h654321);
    tick();
    pix_valid_i = 1'b0;
    wait_req("mr_req");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_req_drop", 32'(mem_req_o), 0);
    check("mr_wcnt", 32'(written_cnt_o), 0);
    check("mr_ccnt", 32'(clipped_cnt_o), 0);
    check("mr_ovf", 32'(overflow_o), 0);
    check("mr_idle", 32'(idle_o), 1);
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_ack_ignored", 32'(mem_req_o), 0);
    end
    mem_ack_i = 1'b0;
    tick();
    check("mr_wcnt_hold", 32'(written_cnt_o), 0);
    check("mr_no_flush", 32'(flush_cnt - base), 0);
    check("mr_idle_end", 32'(idle_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
